// File: rtl/ruler_drv.sv
// Control-side driver for the one-hot LED ruler shifter: synchronises and debounces buttons,
// and produces a registered step strobe plus direction. Optional corner reflection: BOUNCE_EN.
module ruler_drv #(
  parameter int TICK_CNT    = 50000000,
  parameter int DEB_CNT     = 1000000,
  parameter int RULER_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   btn_l_i,
  input  logic                   btn_r_i,
  input  logic                   run_i,
  input  logic [RULER_WIDTH-1:0] ruler_i,
  output logic                   stb_o,
  output logic                   dir_o
);

  localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [2:0]      sync1, sync2;      // {run, btn_r, btn_l}
  logic [DW-1:0]   deb_cnt [2];
  logic [1:0]      stable, stable_q;  // [0] = left, [1] = right
  logic [TW-1:0]   prescale;
  logic            run_sync, press_l, press_r, tick, stb_nxt, dir_nxt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {run_i, btn_r_i, btn_l_i};
      sync2 <= sync1;
    end
  end

  assign run_sync = sync2[2];

  // A level change is accepted only after DEB_CNT consecutive cycles of disagreement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      stable     <= '0;
      stable_q   <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press_l = stable[0] & ~stable_q[0];
  assign press_r = stable[1] & ~stable_q[1];

`ifdef BOUNCE_EN
  localparam logic [RULER_WIDTH-1:0] CORNER_R = RULER_WIDTH'(1);
  localparam logic [RULER_WIDTH-1:0] CORNER_L = CORNER_R << (RULER_WIDTH - 1);
`else
  logic unused_ruler;
  assign unused_ruler = ^ruler_i;
`endif

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    dir_nxt = dir_o;
    if (press_r && !press_l) begin
      dir_nxt = 1'b1;
    end else if (press_l && !press_r) begin
      dir_nxt = 1'b0;
    end
    tick    = (state == RUN) && run_sync && (prescale == TICK_LAST);
    stb_nxt = tick || ((state == IDLE) && (press_l ^ press_r));
`ifdef BOUNCE_EN
    // Reflect off a corner only when no button spoke this cycle.
    if (stb_nxt && !(press_l || press_r)) begin
      if (dir_o && (ruler_i == CORNER_R)) begin
        dir_nxt = 1'b0;
      end else if (!dir_o && (ruler_i == CORNER_L)) begin
        dir_nxt = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      prescale <= '0;
      stb_o    <= 1'b0;
      dir_o    <= 1'b1;
    end else begin
      stb_o <= stb_nxt;
      dir_o <= dir_nxt;
      case (state)
        IDLE: begin
          prescale <= '0;
          if (run_sync) state <= RUN;
        end
        RUN: begin
          if (!run_sync) begin
            state    <= IDLE;
            prescale <= '0;
          end else if (prescale == TICK_LAST) begin
            prescale <= '0;
          end else begin
            prescale <= prescale + TW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          prescale <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ruler_drv.sv
// Self-checking bench for ruler_drv: a history-based model compared every cycle, plus directed
// literal expectations for latency, tick spacing, bounce rejection and corner reflection.
module tb_ruler_drv;

  localparam int TICK_CNT = 4;
  localparam int DEB_CNT  = 3;
  localparam int RW       = 8;

`ifdef BOUNCE_EN
  localparam bit EXP_CORNER_R = 1'b0;
  localparam bit EXP_CORNER_L = 1'b1;
`else
  localparam bit EXP_CORNER_R = 1'b1;
  localparam bit EXP_CORNER_L = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          btn_l = 1'b0, btn_r = 1'b0, run = 1'b0;
  logic [RW-1:0] ruler = '0;
  logic          stb, dir;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_cyc [$];

  always #5 clk = ~clk;

  ruler_drv #(.TICK_CNT(TICK_CNT), .DEB_CNT(DEB_CNT), .RULER_WIDTH(RW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .btn_l_i (btn_l),
    .btn_r_i (btn_r),
    .run_i   (run),
    .ruler_i (ruler),
    .stb_o   (stb),
    .dir_o   (dir)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw inputs recorded per edge since reset; the logic sees each sample two edges later.
  logic [2:0] hist [$];
  bit m_stb = 1'b0, m_dir = 1'b1, m_run = 1'b0;
  bit st_l = 1'b0, st_r = 1'b0, rose_l = 1'b0, rose_r = 1'b0;
  int run_len = 0;

  function automatic bit synced(int n, int b);
    return (n >= 2) ? hist[n-2][b] : 1'b0;
  endfunction

  function automatic bit accepted(int n, int b, bit st);
    for (int k = 0; k < DEB_CNT; k++)
      if (synced(n - k, b) == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      hist.delete();
      m_stb = 1'b0; m_dir = 1'b1; m_run = 1'b0;
      st_l = 1'b0; st_r = 1'b0; rose_l = 1'b0; rose_r = 1'b0;
      run_len = 0;
    end else begin : model_step
      int n;
      bit s_run, tick, d, win_l, win_r;
      hist.push_back({run, btn_r, btn_l});
      n = hist.size() - 1;
      s_run = synced(n, 2);
      tick = 1'b0;
      if (m_run && s_run) begin
        run_len++;
        tick = (run_len % TICK_CNT) == 0;
      end else begin
        run_len = 0;
      end
      d = m_dir;
      if (rose_r && !rose_l) d = 1'b1;
      if (rose_l && !rose_r) d = 1'b0;
      m_stb = tick || (!m_run && (rose_l ^ rose_r));
`ifdef BOUNCE_EN
      if (m_stb && !(rose_l || rose_r)) begin
        if (m_dir && ruler == RW'(1)) d = 1'b0;
        else if (!m_dir && ruler == (RW'(1) << (RW - 1))) d = 1'b1;
      end
`endif
      m_dir = d;
      m_run = s_run;
      win_l = accepted(n, 0, st_l);
      win_r = accepted(n, 1, st_r);
      rose_l = win_l && !st_l;
      rose_r = win_r && !st_r;
      if (win_l) st_l = !st_l;
      if (win_r) st_r = !st_r;
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      check("stb_vs_model", stb, m_stb);
      check("dir_vs_model", dir, m_dir);
      if (stb === 1'b1) pulse_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int count_pulses(int a, int b);
    int c = 0;
    foreach (pulse_cyc[i]) if (pulse_cyc[i] >= a && pulse_cyc[i] <= b) c++;
    return c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_stb(input int budget, output int at, output bit d);
    at = -1;
    d  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stb === 1'b1) begin
        at = cyc;
        d  = dir;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, at, prev, t0;
    bit d;

    // Reset values, then a quiet idle period
    cycles(3);
    check("reset_stb", stb, 0);
    check("reset_dir", dir, 1);
    @(negedge clk); #2 rst_ni = 1'b1;
    base = cyc;
    cycles(101);
    check("idle_no_strobe", count_pulses(base, cyc - 1), 0);

    // Manual left step: held 10 cycles, one pulse after 2 + DEB_CNT + 1 cycles
    base = cyc; btn_l = 1'b1;
    wait_stb(20, at, d);
    check("left_latency", at - base, 6);
    check("left_dir", d, 0);
    cycles(4); btn_l = 1'b0;
    cycles(15);
    check("left_single_pulse", count_pulses(base, cyc - 1), 1);

    // Bounce rejection: 2 high / 1 low never survives DEB_CNT=3
    base = cyc;
    repeat (6) begin
      btn_r = 1'b1; cycles(2);
      btn_r = 1'b0; cycles(1);
    end
    cycles(10);
    check("bounce_no_strobe", count_pulses(base, cyc - 1), 0);
    check("bounce_dir_kept", dir, 0);

    // Manual right step restores dir=1
    base = cyc; btn_r = 1'b1;
    wait_stb(20, at, d);
    check("right_latency", at - base, 6);
    check("right_dir", d, 1);
    cycles(4); btn_r = 1'b0;
    cycles(10);

    // Run ticks every TICK_CNT cycles
    base = cyc; run = 1'b1;
    wait_stb(20, at, d);
    check("run_first_tick", at - base, 7);
    check("run_tick_dir", d, 1);
    prev = at;
    for (int k = 0; k < 3; k++) begin
      wait_stb(8, at, d);
      check("run_period", at - prev, 4);
      check("run_period_dir", d, 1);
      prev = at;
    end
    // Drop run so RUN is left with the prescaler at 2
    run = 1'b0;
    cycles(10);
    check("drop_no_strobe", count_pulses(prev + 1, cyc - 1), 0);
    base = cyc; run = 1'b1;
    wait_stb(20, at, d);
    check("rerun_latency", at - base, 7);
    cycles(6); run = 1'b0;
    cycles(8);

    // Simultaneous press in IDLE: no strobe, no direction change
    base = cyc; btn_l = 1'b1; btn_r = 1'b1;
    cycles(10); btn_l = 1'b0; btn_r = 1'b0;
    cycles(10);
    check("both_no_strobe", count_pulses(base, cyc - 1), 0);
    check("both_dir_kept", dir, 1);

    // Left press landing on a run tick: the tick carries the new direction
    run = 1'b1;
    wait_stb(20, t0, d);
    cycles(2); btn_l = 1'b1;
    wait_stb(8, at, d);
    wait_stb(8, at, d);
    check("aligned_tick_at", at - t0, 8);
    check("aligned_dir", d, 0);
    cycles(4); btn_l = 1'b0; run = 1'b0;
    cycles(12);
    check("aligned_no_extra", count_pulses(t0 + 1, t0 + 8), 2);

    // Corner reflection (or plain wrap without BOUNCE_EN)
    btn_r = 1'b1;
    wait_stb(20, at, d);
    cycles(4); btn_r = 1'b0;
    cycles(10);
    ruler = 8'h01; run = 1'b1;
    wait_stb(20, at, d);
    check("corner_r_dir", d, EXP_CORNER_R);
    cycles(5); run = 1'b0;
    cycles(10);
    ruler = 8'h80; btn_l = 1'b1;
    wait_stb(20, at, d);
    check("press_beats_corner", d, 0);
    cycles(4); btn_l = 1'b0;
    cycles(10);
    run = 1'b1;
    wait_stb(20, at, d);
    check("corner_l_dir", d, EXP_CORNER_L);
    cycles(5); run = 1'b0; ruler = '0;
    cycles(10);

    // Asynchronous reset mid-run, then silence without fresh events
    run = 1'b1;
    cycles(9);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_stb", stb, 0);
    check("async_reset_dir", dir, 1);
    run = 1'b0;
    cycles(3);
    @(negedge clk); #2 rst_ni = 1'b1;
    base = cyc;
    cycles(21);
    check("post_reset_quiet", count_pulses(base, cyc - 1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
